fetch_seq_ctrl: RTL and testbench

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

---
 rtl/fetch_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl -- instruction fetch sequencer between the PC and the I-cache.
//
// Keeps the fetch PC, issues one cache request at a time, presents the returned
// word (or an ADEF fault for a misaligned PC) to decode, and handles
// branch/exception redirects, including dropping data for abandoned requests.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pause_i                  downstream stall; presented entry not consumed
//   exception_flush_i/_pc_i  exception/ertn redirect and its target
//   is_branch_i/target_i     branch redirect and its target
//   inst_req_o, inst_addr_o  cache request and address (= fetch_pc)
//   inst_addr_ok_i           cache accepted the request
//   inst_data_ok_i, rdata_i  cache returns the word
//   inst_valid_o             entry (instruction or fault) valid for decode
//   inst_pc_o, inst_o        PC and word of the presented entry
//   adef_o                   presented entry is an address-error fault
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_i,
    input  logic        exception_flush_i,
    input  logic [31:0] exception_pc_i,
    input  logic        is_branch_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_o,
    output logic        adef_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [31:0] fetch_pc;
    logic [31:0] nxt_pc;
    logic        redirect;
    logic [31:0] target;
    logic        capture;

    // State entered when a new fetch PC is ready to be issued.
    function automatic state_t issue_state(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
    endfunction

    assign redirect    = exception_flush_i | is_branch_i;
    assign target      = exception_flush_i ? exception_pc_i : branch_target_i;
    assign inst_addr_o = fetch_pc;

    always_comb begin
        nxt_state = state;
        nxt_pc    = fetch_pc;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                nxt_state = issue_state(fetch_pc);
            end
            S_REQ: begin
                if (redirect) begin
                    nxt_pc = target;
                    // An accepted request still owes us a data_ok; drain it first.
                    nxt_state = inst_addr_ok_i ? S_DISCARD : issue_state(target);
                end else if (inst_addr_ok_i) begin
                    nxt_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    nxt_pc    = target;
                    nxt_state = inst_data_ok_i ? issue_state(target) : S_DISCARD;
                end else if (inst_data_ok_i) begin
                    capture   = 1'b1;
                    nxt_state = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    nxt_pc = target;
                end
                if (inst_data_ok_i) begin
                    nxt_state = issue_state(redirect ? target : fetch_pc);
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    nxt_pc    = target;
                    nxt_state = issue_state(target);
                end else if (!pause_i) begin
                    nxt_pc    = fetch_pc + 32'd4;
                    nxt_state = issue_state(fetch_pc + 32'd4);
                end
            end
            S_FAULT: begin
                if (redirect) begin
                    nxt_pc    = target;
                    nxt_state = issue_state(target);
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with `state`.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            inst_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            adef_o       <= 1'b0;
            inst_pc_o    <= '0;
            inst_o       <= '0;
        end else begin
            state        <= nxt_state;
            fetch_pc     <= nxt_pc;
            inst_req_o   <= (nxt_state == S_REQ);
            inst_valid_o <= (nxt_state == S_HOLD) || (nxt_state == S_FAULT);
            adef_o       <= (nxt_state == S_FAULT);
            if (capture) begin
                inst_pc_o <= fetch_pc;
                inst_o    <= inst_rdata_i;
            end else if (nxt_state == S_FAULT) begin
                inst_pc_o <= nxt_pc;
                inst_o    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl -- self-checking bench for fetch_seq_ctrl.
// Expected presented entries go into a scoreboard queue when the cache
// response is driven and are popped when decode should see them.
module tb_fetch_seq_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1C000000;

    logic        clk;
    logic        rst;
    logic        pause_i;
    logic        exception_flush_i;
    logic [31:0] exception_pc_i;
    logic        is_branch_i;
    logic [31:0] branch_target_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_o;
    logic        adef_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    fetch_seq_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .pause_i          (pause_i),
        .exception_flush_i(exception_flush_i),
        .exception_pc_i   (exception_pc_i),
        .is_branch_i      (is_branch_i),
        .branch_target_i  (branch_target_i),
        .inst_req_o       (inst_req_o),
        .inst_addr_o      (inst_addr_o),
        .inst_addr_ok_i   (inst_addr_ok_i),
        .inst_data_ok_i   (inst_data_ok_i),
        .inst_rdata_i     (inst_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_pc_o        (inst_pc_o),
        .inst_o           (inst_o),
        .adef_o           (adef_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry condition: DUT in REQ at exp_pc. Exit condition: DUT in REQ at exp_pc+4.
    task automatic do_fetch(input logic [31:0] rdata, input int lat_a, input int lat_d,
                            input int hold_cycles);
        exp_t x;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc) begin n_err++;
            $display("FAIL fetch_start: req=%b addr=%h want req=1 addr=%h", inst_req_o, inst_addr_o, exp_pc); end
        for (int i = 0; i < lat_a; i++) begin
            step();
            n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc) begin n_err++;
                $display("FAIL addr_stable: req=%b addr=%h want req=1 addr=%h", inst_req_o, inst_addr_o, exp_pc); end
        end
        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        for (int i = 0; i < lat_d; i++) begin
            n_vec++; if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++;
                $display("FAIL wait_idle: req=%b valid=%b want 0 0", inst_req_o, inst_valid_o); end
            step();
        end
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = rdata;
        x.pc = exp_pc; x.inst = rdata; x.adef = 1'b0;
        sb.push_back(x);
        step();
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = $urandom;
        if (sb.size() == 0) begin
            n_vec++; n_err++; $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
            x = sb.pop_front();
            n_vec++; if (inst_valid_o !== 1'b1 || inst_pc_o !== x.pc || inst_o !== x.inst ||
                         adef_o !== x.adef || inst_req_o !== 1'b0) begin n_err++;
                $display("FAIL hold_entry: valid=%b pc=%h inst=%h adef=%b req=%b want 1 %h %h %b 0",
                         inst_valid_o, inst_pc_o, inst_o, adef_o, inst_req_o, x.pc, x.inst, x.adef); end
            if (hold_cycles > 0) begin
                pause_i = 1'b1;
                for (int i = 0; i < hold_cycles; i++) begin
                    step();
                    n_vec++; if (inst_valid_o !== 1'b1 || inst_pc_o !== x.pc || inst_o !== x.inst ||
                                 inst_req_o !== 1'b0 || inst_addr_o !== exp_pc) begin n_err++;
                        $display("FAIL pause_stable: valid=%b pc=%h inst=%h req=%b addr=%h want 1 %h %h 0 %h",
                                 inst_valid_o, inst_pc_o, inst_o, inst_req_o, inst_addr_o, x.pc, x.inst, exp_pc); end
                end
                pause_i = 1'b0;
            end
        end
        step();
        exp_pc = exp_pc + 32'd4;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL next_pc: req=%b addr=%h valid=%b want 1 %h 0", inst_req_o, inst_addr_o, inst_valid_o, exp_pc); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pause_i = 1'b0; exception_flush_i = 1'b0; is_branch_i = 1'b0;
        exception_pc_i = '0; branch_target_i = '0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
        step(); step();
        n_vec++; if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0 || adef_o !== 1'b0) begin n_err++;
            $display("FAIL reset_ctl: req=%b valid=%b adef=%b want 0 0 0", inst_req_o, inst_valid_o, adef_o); end
        n_vec++; if (inst_pc_o !== 32'h0 || inst_o !== 32'h0) begin n_err++;
            $display("FAIL reset_data: pc=%h inst=%h want 0 0", inst_pc_o, inst_o); end
        n_vec++; if (inst_addr_o !== RESET_PC) begin n_err++;
            $display("FAIL reset_addr: got %h want %h", inst_addr_o, RESET_PC); end
        rst = 1'b0;
        step();
        exp_pc = RESET_PC;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== RESET_PC) begin n_err++;
            $display("FAIL first_req: req=%b addr=%h want 1 %h", inst_req_o, inst_addr_o, RESET_PC); end
    endtask

    task automatic test_basic();
        do_fetch(32'h02800000, 0, 0, 0);
        n_vec++; if (inst_addr_o !== 32'h1C000004) begin n_err++;
            $display("FAIL basic_next: got %h want %h", inst_addr_o, 32'h1C000004); end
    endtask

    task automatic test_redirect_wait();
        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        is_branch_i = 1'b1; branch_target_i = 32'h1C000100;
        step();
        is_branch_i = 1'b0;
        exp_pc = 32'h1C000100;
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++;
                $display("FAIL discard_quiet: req=%b valid=%b want 0 0", inst_req_o, inst_valid_o); end
            step();
        end
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBADC0DE0;
        step();
        inst_data_ok_i = 1'b0;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL redirect_wait: req=%b addr=%h valid=%b want 1 %h 0", inst_req_o, inst_addr_o, inst_valid_o, exp_pc); end
        // Redirect together with addr_ok, then a second redirect while draining.
        inst_addr_ok_i = 1'b1; is_branch_i = 1'b1; branch_target_i = 32'h1C000300;
        step();
        inst_addr_ok_i = 1'b0;
        branch_target_i = 32'h1C000380;
        n_vec++; if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL req_redirect_acc: req=%b valid=%b want 0 0", inst_req_o, inst_valid_o); end
        step();
        is_branch_i = 1'b0;
        exp_pc = 32'h1C000380;
        n_vec++; if (inst_req_o !== 1'b0 || inst_addr_o !== exp_pc) begin n_err++;
            $display("FAIL discard_redirect: req=%b addr=%h want 0 %h", inst_req_o, inst_addr_o, exp_pc); end
        inst_data_ok_i = 1'b1;
        step();
        inst_data_ok_i = 1'b0;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL discard_exit: req=%b addr=%h valid=%b want 1 %h 0", inst_req_o, inst_addr_o, inst_valid_o, exp_pc); end
    endtask

    task automatic test_flush_priority();
        exception_flush_i = 1'b1; exception_pc_i = 32'h1C008000;
        is_branch_i = 1'b1; branch_target_i = 32'h1C000200;
        step();
        exception_flush_i = 1'b0; is_branch_i = 1'b0;
        exp_pc = 32'h1C008000;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc) begin n_err++;
            $display("FAIL flush_priority: req=%b addr=%h want 1 %h", inst_req_o, inst_addr_o, exp_pc); end
    endtask

    task automatic test_adef();
        exp_t x;
        is_branch_i = 1'b1; branch_target_i = 32'h1C000002;
        step();
        is_branch_i = 1'b0;
        x.pc = 32'h1C000002; x.inst = 32'h0; x.adef = 1'b1;
        sb.push_back(x);
        x = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b1 || adef_o !== x.adef ||
                         inst_pc_o !== x.pc || inst_o !== x.inst) begin n_err++;
                $display("FAIL adef_entry: req=%b valid=%b adef=%b pc=%h inst=%h want 0 1 1 %h %h",
                         inst_req_o, inst_valid_o, adef_o, inst_pc_o, inst_o, x.pc, x.inst); end
            step();
        end
        exception_flush_i = 1'b1; exception_pc_i = 32'h1C000400;
        step();
        exception_flush_i = 1'b0;
        exp_pc = 32'h1C000400;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== exp_pc || adef_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL adef_exit: req=%b addr=%h adef=%b valid=%b want 1 %h 0 0",
                     inst_req_o, inst_addr_o, adef_o, inst_valid_o, exp_pc); end
    endtask

    task automatic test_pause();
        do_fetch(32'h00100013, 1, 2, 5);
    endtask

    task automatic test_reset_mid();
        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (inst_addr_o !== RESET_PC || inst_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL async_reset: addr=%h req=%b valid=%b want %h 0 0", inst_addr_o, inst_req_o, inst_valid_o, RESET_PC); end
        #1 rst = 1'b0;
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEADBEEF;
        step();
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== RESET_PC || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL reset_mid_req: req=%b addr=%h valid=%b want 1 %h 0", inst_req_o, inst_addr_o, inst_valid_o, RESET_PC); end
        step();
        inst_data_ok_i = 1'b0;
        exp_pc = RESET_PC;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== RESET_PC || inst_valid_o !== 1'b0) begin n_err++;
            $display("FAIL stale_data_ok: req=%b addr=%h valid=%b want 1 %h 0", inst_req_o, inst_addr_o, inst_valid_o, RESET_PC); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            do_fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        // Wrap of fetch_pc + 4 past the top of the address space.
        is_branch_i = 1'b1; branch_target_i = 32'hFFFFFFFC;
        step();
        is_branch_i = 1'b0;
        exp_pc = 32'hFFFFFFFC;
        do_fetch(32'h12345678, 0, 1, 0);
        n_vec++; if (inst_addr_o !== 32'h0) begin n_err++;
            $display("FAIL pc_wrap: got %h want %h", inst_addr_o, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect_wait();
        test_flush_priority();
        test_adef();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
